// File: rtl/alu_op_sequencer.sv
// Front-panel sequencer for the Nexys4 ALU: debounced buttons, operand/opcode entry,
// and a start/done handshake with timeout whose result is held for display.
module alu_op_sequencer #(
  parameter int DEB_CYCLES = 4,
  parameter int WIDTH      = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               BTNC,
  input  logic               BTNU,
  input  logic               BTND,
  input  logic               BTNL,
  input  logic               BTNR,
  input  logic [WIDTH-1:0]   sw,
  input  logic               alu_done,
  input  logic [2*WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic [3:0]         opcode,
  output logic               alu_start,
  output logic [2*WIDTH-1:0] result,
  output logic               err,
  output logic [2:0]         state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_SEL_OP = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_SHOW   = 3'd5;

  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  // Button index order doubles as priority order: C, R, L, U, D.
  logic [4:0] w_raw;
  logic [4:0] w_press;
  logic [4:0] w_win;

  assign w_raw = {BTND, BTNU, BTNL, BTNR, BTNC};

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_btn
      logic          r_s1;
      logic          r_s2;
      logic          r_deb;
      logic          r_deb_d;
      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_s1    <= 1'b0;
          r_s2    <= 1'b0;
          r_deb   <= 1'b0;
          r_deb_d <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_s1    <= w_raw[gi];
          r_s2    <= r_s1;
          r_deb_d <= r_deb;
          if (r_s2 == r_deb) begin
            r_cnt <= '0;
          end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
            r_deb <= r_s2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_press[gi] = r_deb & ~r_deb_d;
    end
  endgenerate

  always_comb begin
    w_win = '0;
    if      (w_press[0]) w_win[0] = 1'b1;
    else if (w_press[1]) w_win[1] = 1'b1;
    else if (w_press[2]) w_win[2] = 1'b1;
    else if (w_press[3]) w_win[3] = 1'b1;
    else if (w_press[4]) w_win[4] = 1'b1;
  end

  logic w_c, w_r, w_l, w_u, w_d;
  assign {w_d, w_u, w_l, w_r, w_c} = w_win;

  logic [2:0]         r_state;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [3:0]         r_opcode;
  logic               r_alu_start;
  logic [2*WIDTH-1:0] r_result;
  logic               r_err;
  logic [TW-1:0]      r_tcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_opcode    <= '0;
      r_alu_start <= 1'b0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_tcnt      <= '0;
    end else begin
      r_alu_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_c) r_state <= S_LOAD_A;
        end
        S_LOAD_A: begin
          if (w_c) begin
            r_op_a  <= sw;
            r_state <= S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (w_c) begin
            r_op_b  <= sw;
            r_state <= S_SEL_OP;
          end else if (w_r) begin
            r_state <= S_LOAD_A;
          end
        end
        S_SEL_OP: begin
          if (w_c) begin
            r_state     <= S_EXEC;
            r_alu_start <= 1'b1;
            r_tcnt      <= '0;
          end else if (w_r) begin
            r_state <= S_LOAD_A;
          end else if (w_l) begin
            r_opcode <= 4'd0;
          end else if (w_u) begin
            r_opcode <= r_opcode + 4'd1;
          end else if (w_d) begin
            r_opcode <= r_opcode - 4'd1;
          end
        end
        S_EXEC: begin
          // The launch cycle itself never samples alu_done.
          if (!r_alu_start) begin
            if (alu_done) begin
              r_result <= alu_result;
              r_err    <= 1'b0;
              r_state  <= S_SHOW;
            end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
              r_result <= '0;
              r_err    <= 1'b1;
              r_state  <= S_SHOW;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
        end
        S_SHOW: begin
          if (w_c) begin
            r_state     <= S_EXEC;
            r_alu_start <= 1'b1;
            r_tcnt      <= '0;
          end else if (w_l) begin
            r_state <= S_SEL_OP;
          end else if (w_r) begin
            r_state <= S_LOAD_A;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign op_a      = r_op_a;
  assign op_b      = r_op_b;
  assign opcode    = r_opcode;
  assign alu_start = r_alu_start;
  assign result    = r_result;
  assign err       = r_err;
  assign state     = r_state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a vector table for entry sequences, a behavioural ALU
// responder with programmable latency, and randomized runs checked against a simple model.
module tb_alu_op_sequencer;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 16;

  localparam logic [4:0] B_C = 5'b00001;
  localparam logic [4:0] B_R = 5'b00010;
  localparam logic [4:0] B_L = 5'b00100;
  localparam logic [4:0] B_U = 5'b01000;
  localparam logic [4:0] B_D = 5'b10000;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [4:0]         btn = '0;
  logic [WIDTH-1:0]   sw = '0;
  logic               resp_done = 1'b0;
  logic [15:0]        resp_result = '0;
  logic               extra_done = 1'b0;
  logic [15:0]        extra_result = '0;
  wire                alu_done;
  wire  [15:0]        alu_result;
  logic [WIDTH-1:0]   op_a, op_b;
  logic [3:0]         opcode;
  logic               alu_start;
  logic [15:0]        result;
  logic               err;
  logic [2:0]         state;

  assign alu_done   = resp_done | extra_done;
  assign alu_result = extra_done ? extra_result : resp_result;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DEB_CYCLES(4), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .BTNC(btn[0]), .BTNU(btn[3]), .BTND(btn[4]), .BTNL(btn[2]), .BTNR(btn[1]),
    .sw(sw), .alu_done(alu_done), .alu_result(alu_result),
    .op_a(op_a), .op_b(op_b), .opcode(opcode), .alu_start(alu_start),
    .result(result), .err(err), .state(state)
  );

  // Behavioural ALU: answers alu_delay cycles after the start cycle (0 = never).
  int alu_delay = 0;
  int cd = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int show_cyc = 0;
  logic [2:0] prev_state = 3'd0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (cd > 0) begin
      cd        <= cd - 1;
      resp_done <= (cd == 1);
    end else begin
      resp_done <= 1'b0;
    end
    if (alu_start) begin
      cd        <= alu_delay;
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
    if (state == 3'd5 && prev_state != 3'd5) show_cyc <= cyc;
    prev_state <= state;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic press(input logic [4:0] m);
    @(negedge clk);
    btn = m;
    repeat (10) @(negedge clk);
    btn = '0;
    repeat (25) @(negedge clk);
  endtask

  // Runs one EXEC from SEL_OP/SHOW and checks it against the latency/result model.
  task automatic exec_check(input string name, input logic [4:0] m, input int d,
                            input logic [15:0] r);
    int s0;
    int lat_exp;
    logic [15:0] res_exp;
    logic err_exp;
    alu_delay   = d;
    resp_result = r;
    s0 = start_cnt;
    press(m);
    if (d >= 1 && d <= TIMEOUT) begin
      res_exp = r; err_exp = 1'b0; lat_exp = d + 1;
    end else begin
      res_exp = '0; err_exp = 1'b1; lat_exp = TIMEOUT + 1;
    end
    check({name, " start_pulses"}, 64'(start_cnt - s0), 64'd1);
    check({name, " latency"}, 64'(show_cyc - start_cyc), 64'(lat_exp));
    check({name, " result/err/state"}, {45'd0, res_exp, err_exp, 3'd5}, {45'd0, result, err, state});
  endtask

  typedef struct {
    logic [4:0] btn;
    logic [7:0] sw;
    logic [2:0] st;
    logic [3:0] opc;
    logic [7:0] a;
    logic [7:0] b;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int lat;
    int n_ops;
    int act;
    int d;
    logic [3:0] opc_model;
    logic [15:0] r;
    logic seen;
    int s0;

    vecs[0]  = '{B_C, 8'h2A, 3'd2, 4'd0,  8'h2A, 8'h00};
    vecs[1]  = '{B_C, 8'h05, 3'd3, 4'd0,  8'h2A, 8'h05};
    vecs[2]  = '{B_D, 8'hFF, 3'd3, 4'd15, 8'h2A, 8'h05};
    vecs[3]  = '{B_U, 8'hFF, 3'd3, 4'd0,  8'h2A, 8'h05};
    vecs[4]  = '{B_U, 8'hFF, 3'd3, 4'd1,  8'h2A, 8'h05};
    vecs[5]  = '{B_U, 8'hFF, 3'd3, 4'd2,  8'h2A, 8'h05};
    vecs[6]  = '{B_U, 8'hFF, 3'd3, 4'd3,  8'h2A, 8'h05};
    vecs[7]  = '{B_L, 8'hFF, 3'd3, 4'd0,  8'h2A, 8'h05};
    vecs[8]  = '{B_R, 8'hFF, 3'd1, 4'd0,  8'h2A, 8'h05};
    vecs[9]  = '{B_C, 8'h11, 3'd2, 4'd0,  8'h11, 8'h05};
    vecs[10] = '{B_R, 8'hFF, 3'd1, 4'd0,  8'h11, 8'h05};
    vecs[11] = '{B_C, 8'h2A, 3'd2, 4'd0,  8'h2A, 8'h05};
    vecs[12] = '{B_C, 8'h05, 3'd3, 4'd0,  8'h2A, 8'h05};
    vecs[13] = '{B_U | B_D, 8'hFF, 3'd3, 4'd1, 8'h2A, 8'h05};
    vecs[14] = '{B_L | B_U, 8'hFF, 3'd3, 4'd0, 8'h2A, 8'h05};
    vecs[15] = '{B_U, 8'hFF, 3'd3, 4'd1,  8'h2A, 8'h05};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset outputs", {25'd0, op_a, op_b, opcode, alu_start, result, err, state}, 64'd0);

    // Short glitch, then a clean held press with latency measured from the raw rise.
    btn = B_C;
    repeat (2) @(negedge clk);
    btn = '0;
    repeat (12) @(negedge clk);
    check("glitch ignored", 64'(state), 64'd0);
    btn = B_C;
    lat = 0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      if (state == 3'd1 && lat == 0) lat = k;
    end
    @(negedge clk);
    btn = '0;
    repeat (12) @(negedge clk);
    check("press latency", 64'(lat), 64'd7);

    for (int i = 0; i < 16; i++) begin
      sw = vecs[i].sw;
      press(vecs[i].btn);
      check($sformatf("vec%0d st/opc/a/b", i), {36'd0, state, opcode, op_a, op_b},
            {36'd0, vecs[i].st, vecs[i].opc, vecs[i].a, vecs[i].b});
    end
    opc_model = 4'd1;

    exec_check("handshake", B_C, 3, 16'h00D2);
    extra_result = 16'h7777;
    @(negedge clk); extra_done = 1'b1;
    @(negedge clk); extra_done = 1'b0;
    repeat (3) @(negedge clk);
    check("done in SHOW ignored", {result, err, state}, {16'h00D2, 1'b0, 3'd5});
    exec_check("rerun from SHOW", B_C, 3, 16'h1234);

    press(B_L);
    check("SHOW L -> SEL_OP", 64'(state), 64'd3);
    exec_check("priority C over R", B_C | B_R, 2, 16'h0042);

    // alu_done held high from before launch: only the cycle after start may capture it.
    alu_delay = 0;
    extra_result = 16'hBEEF;
    extra_done = 1'b1;
    press(B_C);
    extra_done = 1'b0;
    check("done in start cycle ignored", 64'(show_cyc - start_cyc), 64'd2);
    check("held done captured", {result, err}, {16'hBEEF, 1'b0});

    exec_check("done at last cycle", B_C, TIMEOUT, 16'h5A5A);
    exec_check("done one cycle late", B_C, TIMEOUT + 1, 16'hA5A5);
    exec_check("success clears err", B_C, 1, 16'h0F0F);

    for (int it = 0; it < 12; it++) begin
      press(B_L);
      n_ops = $urandom_range(0, 3);
      for (int j = 0; j < n_ops; j++) begin
        act = $urandom_range(0, 2);
        if (act == 0) begin press(B_U); opc_model = opc_model + 4'd1; end
        else if (act == 1) begin press(B_D); opc_model = opc_model - 4'd1; end
        else begin press(B_L); opc_model = 4'd0; end
      end
      check($sformatf("rand%0d opcode", it), 64'(opcode), 64'(opc_model));
      d = $urandom_range(1, 20);
      r = 16'($urandom);
      exec_check($sformatf("rand%0d exec d=%0d", it, d), B_C, d, r);
      check($sformatf("rand%0d operands", it), {48'd0, op_a, op_b}, {48'd0, 8'h2A, 8'h05});
    end

    exec_check("timeout", B_C, 0, 16'hDEAD);
    extra_result = 16'h3333;
    @(negedge clk); extra_done = 1'b1;
    @(negedge clk); extra_done = 1'b0;
    repeat (3) @(negedge clk);
    check("late done ignored", {result, err}, {16'h0000, 1'b1});

    // Reset two cycles into EXEC; the pending ALU answer then arrives while idle.
    alu_delay = 5;
    resp_result = 16'h9999;
    s0 = start_cnt;
    @(negedge clk);
    btn = B_C;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(posedge clk); #1;
      if (alu_start) seen = 1'b1;
    end
    check("reset-test start seen", 64'(seen), 64'd1);
    btn = '0;
    @(posedge clk);
    @(posedge clk); #1;
    check("still in EXEC before reset", 64'(state), 64'd4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid-EXEC reset outputs", {25'd0, op_a, op_b, opcode, alu_start, result, err, state}, 64'd0);
    repeat (30) @(negedge clk);
    check("done after reset ignored", {result, err, state}, 20'd0);
    check("single start in reset test", 64'(start_cnt - s0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
